inst_ram_loader: RTL

Debug-mode program loader upstream of the CPU's instruction RAM write port. Accepts a framed byte stream (length, big-endian instruction words, checksum) over a valid/ready byte interface and assembles 32-bit words. Issues one-cycle instruction-RAM write strobes at incrementing byte addresses. Holds the CPU in debug mode for the duration of the load.

---
 rtl/loader_pkg.sv | 27 ++
 rtl/word_packer.sv | 42 ++++
 rtl/inst_ram_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-RAM program loader.
//   state_t     : session FSM states
//   LANES       : bytes per instruction word
//   CSUM_W      : checksum accumulator width
//   LANE_CNT_W  : width of the byte-lane counter
//   takes_bytes : true for the states in which the loader accepts stream bytes
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam int LANES      = 4;
  localparam int CSUM_W     = 8;
  localparam int LANE_CNT_W = $clog2(LANES);

  function automatic logic takes_bytes(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-to-word packer: shifts stream bytes in MSB-first and flags the byte
// that completes a word.
//   clk, reset    : clock, asynchronous active-low reset
//   i_clear       : drop any partial word (new session)
//   i_shift       : shift i_byte in this cycle
//   i_byte        : incoming stream byte
//   o_word_next   : word formed by the held bytes plus i_byte
//   o_word_full   : this shift supplies the last byte of a word
module word_packer
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_shift,
  input  logic [7:0]           i_byte,
  output logic [8*LANES-1:0]   o_word_next,
  output logic                 o_word_full
);

  // Only the lower LANES-1 bytes need holding; the oldest byte falls off
  // the top once the word completes.
  logic [8*(LANES-1)-1:0] r_word;
  logic [LANE_CNT_W-1:0]  r_count;

  assign o_word_next = {r_word, i_byte};
  assign o_word_full = i_shift && (r_count == LANE_CNT_W'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_word  <= o_word_next[8*(LANES-1)-1:0];
      r_count <= r_count + 1'b1;  // wraps to 0 after the last lane
    end
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Debug-mode program loader feeding the instruction-RAM write port.
// Frame: LEN_HI, LEN_LO, 4*N data bytes (words MSB-first), checksum byte
// (8-bit sum of data bytes). Holds the CPU in debug for the whole session.
//   clk, reset             : clock, asynchronous active-low reset
//   start, abort           : open a session (IDLE only) / abandon it
//   rx_valid, rx_data      : byte stream in
//   rx_ready               : byte accepted this cycle when rx_valid
//   debug                  : session active
//   inst_ram_write_*       : one-cycle write strobe, word and byte address
//   done                   : one-cycle end-of-session pulse
//   error                  : sticky fault flag, cleared by an accepted start
module inst_ram_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [15:0] inst_ram_write_address,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t              r_state, w_next;
  logic                r_rx_ready, r_debug, r_we, r_done, r_error;
  logic [31:0]         r_wdata;
  logic [15:0]         r_addr, r_remaining;
  logic [7:0]          r_len_hi;
  logic [CSUM_W-1:0]   r_acc;

  logic                w_accept, w_start_go, w_shift, w_word_full;
  logic [15:0]         w_len;
  logic                w_len_zero, w_len_over;
  logic [31:0]         w_word_next;
  logic                w_rx_ready_d, w_debug_d, w_we_d, w_done_d, w_error_d;

  assign w_accept   = rx_valid && r_rx_ready;
  assign w_start_go = (r_state == IDLE) && start && !abort;
  assign w_shift    = (r_state == DATA) && w_accept && !abort;
  assign w_len      = {r_len_hi, rx_data};
  assign w_len_zero = (w_len == 16'h0000);
  assign w_len_over = ({1'b0, w_len} > LP_MAX);

  word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_go),
    .i_shift     (w_shift),
    .i_byte      (rx_data),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full)
  );

  // State register; outputs are registered from the next state so every
  // output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rx_ready <= 1'b0;
      r_debug    <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= w_rx_ready_d;
      r_debug    <= w_debug_d;
      r_we       <= w_we_d;
      r_done     <= w_done_d;
      r_error    <= w_error_d;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = LEN_HI;
        LEN_HI:  if (w_accept) w_next = LEN_LO;
        LEN_LO:  if (w_accept) begin
                   if (w_len_zero)      w_next = CHECK;
                   else if (w_len_over) w_next = IDLE;
                   else                 w_next = DATA;
                 end
        DATA:    if (w_word_full) w_next = WRITE;
        WRITE:   w_next = (r_remaining == 16'd1) ? CHECK : DATA;
        CHECK:   if (w_accept) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Output decode of the next state, plus the sticky error update.
  always_comb begin
    w_rx_ready_d = takes_bytes(w_next);
    w_debug_d    = (w_next != IDLE);
    w_we_d       = (w_next == WRITE);
    w_done_d     = (w_next == DONE);
    w_error_d    = r_error;
    if (abort)
      w_error_d = 1'b1;
    else if (w_start_go)
      w_error_d = 1'b0;
    else if ((r_state == LEN_LO) && w_accept && w_len_over)
      w_error_d = 1'b1;
    else if ((r_state == CHECK) && w_accept && (rx_data != r_acc))
      w_error_d = 1'b1;
  end

  // Session datapath: length, word count, address, checksum, write word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_hi    <= '0;
      r_remaining <= '0;
      r_addr      <= BASE_ADDR;
      r_acc       <= '0;
      r_wdata     <= '0;
    end else if (!abort) begin
      if (w_start_go) begin
        r_acc  <= '0;
        r_addr <= BASE_ADDR;
      end
      if ((r_state == LEN_HI) && w_accept) r_len_hi <= rx_data;
      if ((r_state == LEN_LO) && w_accept) r_remaining <= w_len;
      if (w_shift) r_acc <= r_acc + rx_data;
      if (w_word_full) r_wdata <= w_word_next;
      if (r_state == WRITE) begin
        r_addr      <= r_addr + 16'd4;  // 16-bit wrap is intentional
        r_remaining <= r_remaining - 16'd1;
      end
    end
  end

  assign rx_ready               = r_rx_ready;
  assign debug                  = r_debug;
  assign inst_ram_write_enable  = r_we;
  assign inst_ram_write_data    = r_wdata;
  assign inst_ram_write_address = r_addr;
  assign done                   = r_done;
  assign error                  = r_error;

endmodule
